// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// Carries the sub control only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per clock through a ripple of full adders.
// Define SERIAL_ADDER_SUB_EN to add a sub control computing a + ~b + 1.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic             rc;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    dsum = '0;
    rc   = carry;
    // NOTE: blocking assignments here let rc ripple from cell to cell within
    // one evaluation, exactly like a chain of full adders.
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i] = a_sr[i] ^ b_sr[i] ^ rc;
      rc      = (a_sr[i] & b_sr[i]) | (rc & (a_sr[i] ^ b_sr[i]));
    end
    dcarry = rc;
  end

  // New digit enters at the top; the widened concat also covers DIGIT == WIDTH.
  assign res_next = WIDTH'({dsum, res_sr} >> DIGIT);
  assign last     = (cnt == CNT_W'(N - 1));

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
`ifdef SERIAL_ADDER_SUB_EN
            b_sr   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.cin;
`else
            b_sr   <= bus.b;
            carry  <= bus.cin;
`endif
            res_sr <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          carry  <= dcarry;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            sum_q  <= res_next;
            cout_q <= dcarry;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: three serial_adder instances (DIGIT = 1, 2, 4, WIDTH = 8)
// driven by directed and random operations, compared against plain arithmetic.
module tb_serial_adder;
  logic clk;
  logic rst;

  logic       start_v [3];
  logic [7:0] a_v     [3];
  logic [7:0] b_v     [3];
  logic       cin_v   [3];
  logic       sub_v   [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic [7:0] sum_o   [3];
  logic       cout_o  [3];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  serial_adder_if #(.WIDTH(8)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
    assign bus[g].start = start_v[g];
    assign bus[g].a     = a_v[g];
    assign bus[g].b     = b_v[g];
    assign bus[g].cin   = cin_v[g];
`ifdef SERIAL_ADDER_SUB_EN
    assign bus[g].sub   = sub_v[g];
`endif
    assign busy_o[g] = bus[g].busy;
    assign done_o[g] = bus[g].done;
    assign sum_o[g]  = bus[g].sum;
    assign cout_o[g] = bus[g].cout;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cycles(input int i);
    return 8 >> i;
  endfunction

  // Reference: {cout, sum} as plain 9-bit arithmetic.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} + 9'd256 - {1'b0, b};
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[d%0d] observed=%0h expected=%0h", tag, 1 << idx, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic st);
    a_v[i] = a; b_v[i] = b; cin_v[i] = cin; sub_v[i] = sub; start_v[i] = st;
  endtask

  // One operation on all instances, cycle-by-cycle busy/done/result checks.
  task automatic run_all(input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
    logic [8:0] exp;
    exp = model(a, b, cin, sub);
    for (int i = 0; i < 3; i++) drive(i, a, b, cin, sub, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      for (int i = 0; i < 3; i++) begin
        check("busy", i, 32'(busy_o[i]), 32'(c < cycles(i)));
        check("done", i, 32'(done_o[i]), 32'(c == cycles(i)));
        if (c == cycles(i)) begin
          check("sum", i, 32'(sum_o[i]), 32'(exp[7:0]));
          check("cout", i, 32'(cout_o[i]), 32'(exp[8]));
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("sum_held", i, 32'(sum_o[i]), 32'(exp[7:0]));
      check("cout_held", i, 32'(cout_o[i]), 32'(exp[8]));
    end
  endtask

  // Start re-asserted in the DONE cycle is accepted with no bubble.
  task automatic b2b(input int i);
    int n;
    n = cycles(i);
    drive(i, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    tick();
    start_v[i] = 1'b0;
    repeat (n) tick();
    check("b2b_done1", i, 32'(done_o[i]), 32'd1);
    check("b2b_sum1", i, 32'(sum_o[i]), 32'h80);
    check("b2b_cout1", i, 32'(cout_o[i]), 32'd0);
    drive(i, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    tick();
    start_v[i] = 1'b0;
    check("b2b_busy", i, 32'(busy_o[i]), 32'd1);
    check("b2b_nodone", i, 32'(done_o[i]), 32'd0);
    check("b2b_hold", i, 32'(sum_o[i]), 32'h80);
    repeat (n - 1) tick();
    check("b2b_early", i, 32'(done_o[i]), 32'd0);
    tick();
    check("b2b_done2", i, 32'(done_o[i]), 32'd1);
    check("b2b_sum2", i, 32'(sum_o[i]), 32'h02);
    check("b2b_idle", i, 32'(busy_o[i]), 32'd0);
    tick();
  endtask

  // Start pulsed mid-RUN with different operands must be ignored.
  task automatic ignore_mid(input int i, input int at);
    int dones;
    dones = 0;
    drive(i, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    tick();
    start_v[i] = 1'b0;
    for (int c = 0; c < 2 * cycles(i) + 2; c++) begin
      if (done_o[i]) begin
        dones++;
        check("ign_sum", i, 32'(sum_o[i]), 32'h33);
      end
      if (c == at) drive(i, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b1);
      tick();
      start_v[i] = 1'b0;
    end
    check("ign_dones", i, 32'(dones), 32'd1);
  endtask

  initial begin
    int seen;
    logic [7:0] ra, rb;
    logic rc, rs;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", i, 32'(busy_o[i]), 32'd0);
      check("rst_done", i, 32'(done_o[i]), 32'd0);
      check("rst_sum", i, 32'(sum_o[i]), 32'd0);
      check("rst_cout", i, 32'(cout_o[i]), 32'd0);
    end
    rst = 1'b0;
    tick();

    run_all(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_all(8'hFF, 8'h01, 1'b0, 1'b0);
    run_all(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_all(8'h7F, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) b2b(i);
    for (int i = 0; i < 3; i++) ignore_mid(i, (cycles(i) > 3) ? 3 : cycles(i) - 1);

    // Reset in the middle of RUN discards the operation.
    for (int i = 0; i < 3; i++) drive(i, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mrst_busy", i, 32'(busy_o[i]), 32'd0);
      check("mrst_done", i, 32'(done_o[i]), 32'd0);
      check("mrst_sum", i, 32'(sum_o[i]), 32'd0);
      check("mrst_cout", i, 32'(cout_o[i]), 32'd0);
    end
    seen = 0;
    repeat (10) begin
      tick();
      for (int i = 0; i < 3; i++) seen += int'(done_o[i]) + int'(busy_o[i]);
    end
    check("mrst_quiet", 0, 32'(seen), 32'd0);
    run_all(8'h01, 8'h02, 1'b0, 1'b0);

    repeat (16) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_all(ra, rb, rc, rs);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_all(8'h10, 8'h01, 1'b0, 1'b1);
    run_all(8'h01, 8'h02, 1'b1, 1'b1);
    run_all(8'h33, 8'h33, 1'b1, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder; successor to the single-bit gate-level full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a DIGIT-long ripple of full-adder cells and a registered carry.
- Start/busy/done handshake, so it can sit behind a simple controller in area-constrained datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- DIGIT, 1, bits added per cycle; must divide WIDTH exactly, 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while the add is in progress.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  WIDTH  result; registered, held until the next completion.
- cout  output  1  carry-out; registered, held with sum.

Behaviour:
- Let N = WIDTH/DIGIT.
- States:
  - IDLE: waiting for start.
  - RUN: adding digits.
  - DONE: result just written, lasts exactly 1 cycle.
- Reset (rst=1 at an edge), from any state including mid-RUN:
  - state goes to IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry and counter are cleared.
  - The in-flight operation is discarded with no done pulse.
- Start acceptance:
  - Accepted when start=1 at an edge with state IDLE or DONE, so back-to-back operation has no bubble.
  - On acceptance: a, b and cin are loaded into the internal operand shift registers and the carry flop; counter=0; state goes to RUN.
  - start while in RUN is ignored; the operands being processed are unaffected.
- Each edge in RUN:
  - Add the low DIGIT bits of the A and B shift registers with the carry flop, through a ripple of DIGIT full-adder cells.
  - The DIGIT sum bits shift into the top of the internal result register (right shift; LSB digit is processed first).
  - The carry flop takes the ripple carry-out.
  - The operand registers shift right by DIGIT; the counter increments.
- Completion:
  - On the edge that processes digit N-1, the full result is written to sum, the final carry to cout, and state goes to DONE.
  - done=1 for exactly the cycle in DONE; sum/cout are valid from that cycle and held until the next completion or reset.
- busy=1 exactly while state is RUN, i.e. for N cycles. It is 0 in IDLE and DONE.
- Latency: with start accepted at edge k, done is high between edges k+N and k+N+1.
- Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of a+b+cin. No other status flags.
- Input changes on a, b or cin after acceptance have no effect.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands on the accepted start.
  - If sub=1, the block computes a + ~b + 1, with cin ignored.
  - sum = (a - b) mod 2^WIDTH; cout = 1 means no borrow (a >= b unsigned).
  - If sub=0, behaviour is identical to the base block.
- Undefined: no sub port; add only. Timing and handshake are identical in both builds.

Test Plan:
- WIDTH=8, DIGIT=1; a=0x5A, b=0x3C, cin=0, start pulse -> busy high for 8 cycles; done pulses 8 cycles after the start edge; sum=0x96, cout=0.
- WIDTH=8, DIGIT=1; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- WIDTH=8, DIGIT=4; a=0x7F, b=0x01 -> done 2 cycles after start, sum=0x80, cout=0. Start asserted again in the DONE cycle with a=0x01, b=0x01 -> accepted, next done 2 cycles later, sum=0x02.
- Start with a=0x11, b=0x22, then pulse start with a=0xAA, b=0xAA at cycle 3 of RUN -> second start ignored; sum=0x33, and only one done pulse.
- Assert rst at cycle 4 of an 8-cycle RUN -> next cycle busy=0, sum=0, cout=0, no done pulse. A subsequent start with a=0x01, b=0x02 -> sum=0x03.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8, DIGIT=2; sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1. sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.
